mask_bbox_track: RTL and testbench

MASK_BBOX_TRACK -- requirements
Module: mask_bbox_track

---
 rtl/tracker_pkg.sv | 6 +
 rtl/mask_bbox_track_if.sv | 16 +
 rtl/pix_coord_cnt.sv | 37 +++
 rtl/mask_bbox_track.sv | 78 +++++++
 tb/tb_mask_bbox_track.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/tracker_pkg.sv
// tracker_pkg: shared widths and FSM state encoding for the mask bounding-box tracker
package tracker_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W = 20;
  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;
endpackage

// File: rtl/mask_bbox_track_if.sv
// mask_bbox_track_if: pixel stream in (pre_imgbit/clken/hs/vs) and committed box out (bounds, valid, update, pix_cnt); master drives pixels, slave is the tracker
interface mask_bbox_track_if;
  import tracker_pkg::*;
  logic pre_imgbit, pre_clken, pre_hs, pre_vs;
  logic [COORD_W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic box_valid, box_update;
  logic [CNT_W-1:0] pix_cnt;
  modport master (
    output pre_imgbit, pre_clken, pre_hs, pre_vs,
    input box_xmin, box_xmax, box_ymin, box_ymax, box_valid, box_update, pix_cnt
  );
  modport slave (
    input pre_imgbit, pre_clken, pre_hs, pre_vs,
    output box_xmin, box_xmax, box_ymin, box_ymax, box_valid, box_update, pix_cnt
  );
endinterface

// File: rtl/pix_coord_cnt.sv
// pix_coord_cnt: saturating x/y pixel coordinates plus pixel-enable and vs-rise strobes (in: clk, rst, clr_y, pre_clken, pre_hs, pre_vs; out: x, y, pix_en, vs_rise)
module pix_coord_cnt
  import tracker_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_y,
  input  logic               pre_clken,
  input  logic               pre_hs,
  input  logic               pre_vs,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_en,
  output logic               vs_rise
);
  logic hs_d, vs_d, line_any, hs_fall;
  assign pix_en = pre_clken && pre_hs;
  assign hs_fall = hs_d && !pre_hs;
  assign vs_rise = pre_vs && !vs_d;
  always_ff @(posedge clk)
    if (rst) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      line_any <= 1'b0;
      x <= '0;
      y <= '0;
    end else begin
      hs_d <= pre_hs;
      vs_d <= pre_vs;
      line_any <= hs_fall ? 1'b0 : line_any || pix_en;
      x <= hs_fall ? '0 : (pix_en && x < COORD_W'(IMG_W - 1)) ? x + COORD_W'(1) : x;
      y <= clr_y ? '0 : (hs_fall && line_any && y < COORD_W'(IMG_H - 1)) ? y + COORD_W'(1) : y;
    end
endmodule

// File: rtl/mask_bbox_track.sv
// mask_bbox_track: per-frame mask bounding box and pixel count committed on each vs rise (ports: clk, rst, bus slave); BOX_HOLD_EN enables coasting the last box for up to HOLD_FRAMES failed frames
module mask_bbox_track
  import tracker_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MIN_PIX = 64,
  parameter int HOLD_FRAMES = 4
) (
  input logic clk,
  input logic rst,
  mask_bbox_track_if.slave bus
);
  state_t state;
  logic [COORD_W-1:0] x, y, xmin, xmax, ymin, ymax;
  logic [CNT_W-1:0] pix_acc;
  logic pix_en, vs_rise, clr_y, hit, pass, coast;
  assign clr_y = state == COMMIT || (state == IDLE && vs_rise);
  assign hit = state == ACTIVE && pix_en && bus.pre_imgbit;
  assign pass = pix_acc >= CNT_W'(MIN_PIX);
`ifdef BOX_HOLD_EN
  localparam int FW = $clog2(HOLD_FRAMES + 2);
  logic [FW-1:0] fail_cnt;
  assign coast = !pass && fail_cnt != FW'(HOLD_FRAMES);
  always_ff @(posedge clk)
    if (rst) fail_cnt <= '0;
    else if (state == COMMIT) fail_cnt <= pass ? '0 : coast ? fail_cnt + FW'(1) : fail_cnt;
`else
  assign coast = HOLD_FRAMES < 0;
`endif
  pix_coord_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk(clk), .rst(rst), .clr_y(clr_y), .pre_clken(bus.pre_clken), .pre_hs(bus.pre_hs),
    .pre_vs(bus.pre_vs), .x(x), .y(y), .pix_en(pix_en), .vs_rise(vs_rise)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      xmin <= '1;
      ymin <= '1;
      xmax <= '0;
      ymax <= '0;
      pix_acc <= '0;
      bus.box_xmin <= '0;
      bus.box_xmax <= '0;
      bus.box_ymin <= '0;
      bus.box_ymax <= '0;
      bus.box_valid <= 1'b0;
      bus.box_update <= 1'b0;
      bus.pix_cnt <= '0;
    end else begin
      state <= state == IDLE ? (vs_rise ? ACTIVE : IDLE) : state == ACTIVE ? (vs_rise ? COMMIT : ACTIVE) : ACTIVE;
      bus.box_update <= state == COMMIT;
      if (hit) begin
        xmin <= x < xmin ? x : xmin;
        xmax <= x > xmax ? x : xmax;
        ymin <= y < ymin ? y : ymin;
        ymax <= y > ymax ? y : ymax;
        pix_acc <= &pix_acc ? pix_acc : pix_acc + CNT_W'(1);
      end
      if (state != ACTIVE) begin
        xmin <= '1;
        ymin <= '1;
        xmax <= '0;
        ymax <= '0;
        pix_acc <= '0;
      end
      if (state == COMMIT) begin
        bus.pix_cnt <= pix_acc;
        if (pass || !coast) begin
          bus.box_xmin <= pass ? xmin : '0;
          bus.box_xmax <= pass ? xmax : '0;
          bus.box_ymin <= pass ? ymin : '0;
          bus.box_ymax <= pass ? ymax : '0;
          bus.box_valid <= pass;
        end
      end
    end
endmodule

// File: tb/tb_mask_bbox_track.sv
// tb_mask_bbox_track: randomized frame stimulus checked against a per-frame bounding-box reference model
module tb_mask_bbox_track;
  localparam int W = 24, H = 16, MINP = 8, HOLD = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mask_bbox_track_if bus();
  mask_bbox_track #(.IMG_W(W), .IMG_H(H), .MIN_PIX(MINP), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int n_vec = 0, n_err = 0;
  int a_xmin, a_xmax, a_ymin, a_ymax, a_cnt, f_ny;
  int m_xmin, m_xmax, m_ymin, m_ymax, m_cnt, m_fail;
  logic m_valid;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_xmin"}, bus.box_xmin, 0);
    chk({tag, "_xmax"}, bus.box_xmax, 0);
    chk({tag, "_ymin"}, bus.box_ymin, 0);
    chk({tag, "_ymax"}, bus.box_ymax, 0);
    chk({tag, "_valid"}, bus.box_valid, 0);
    chk({tag, "_update"}, bus.box_update, 0);
    chk({tag, "_pix_cnt"}, bus.pix_cnt, 0);
  endtask
  task automatic m_clear();
    m_valid = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_cnt = 0; m_fail = 0;
  endtask
  task automatic add(input int px, input int py);
    a_xmin = px < a_xmin ? px : a_xmin;
    a_xmax = px > a_xmax ? px : a_xmax;
    a_ymin = py < a_ymin ? py : a_ymin;
    a_ymax = py > a_ymax ? py : a_ymax;
    a_cnt++;
  endtask
  task automatic m_commit();
    m_cnt = a_cnt;
    if (a_cnt >= MINP) begin
      m_valid = 1; m_xmin = a_xmin; m_xmax = a_xmax; m_ymin = a_ymin; m_ymax = a_ymax; m_fail = 0;
    end
`ifdef BOX_HOLD_EN
    else if (m_fail < HOLD) m_fail++;
`endif
    else begin
      m_valid = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    end
  endtask
  task automatic drive(input logic hs, input logic ck, input logic b);
    @(negedge clk);
    bus.pre_hs = hs;
    bus.pre_clken = ck;
    bus.pre_imgbit = b;
  endtask
  task automatic frame(input int mode, input int nl, input int np, input int dens);
    int idx;
    logic ck, b, skip;
    a_xmin = 2047; a_xmax = 0; a_ymin = 2047; a_ymax = 0; a_cnt = 0; f_ny = 0;
    for (int l = 0; l < nl; l++) begin
      idx = 0;
      skip = mode == 0 && $urandom_range(7) == 0;
      for (int p = 0; p < np; p++) begin
        ck = mode == 0 ? ($urandom_range(3) != 0 && !skip) : 1'b1;
        b = mode == 0 ? ($urandom_range(99) < dens) :
            mode == 1 ? (idx >= 5 && idx <= 14 && l >= 3 && l <= 10) :
            mode == 2 ? (l == 2 && idx < MINP - 1) :
            mode == 3 ? (l == nl - 1 && p >= np - MINP) : 1'b0;
        if (ck) begin
          if (b) add(idx < W - 1 ? idx : W - 1, f_ny < H - 1 ? f_ny : H - 1);
          idx++;
        end
        drive(1'b1, ck, ck ? b : 1'($urandom_range(1)));
      end
      if (idx > 0) f_ny++;
      drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic vsync(input bit commit, input bit coinc);
    int len;
    len = $urandom_range(1, 4);
    @(negedge clk);
    bus.pre_vs = 1'b1;
    bus.pre_hs = coinc;
    bus.pre_clken = coinc;
    bus.pre_imgbit = coinc;
    if (coinc) add(0, f_ny < H - 1 ? f_ny : H - 1);
    if (commit) m_commit();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.pre_hs = 1'b0;
      bus.pre_clken = 1'b0;
      bus.pre_imgbit = 1'b0;
      chk($sformatf("box_update_k%0d", k), bus.box_update, commit && k == 2);
      if (commit && k == 2) begin
        chk("box_xmin", bus.box_xmin, m_xmin);
        chk("box_xmax", bus.box_xmax, m_xmax);
        chk("box_ymin", bus.box_ymin, m_ymin);
        chk("box_ymax", bus.box_ymax, m_ymax);
        chk("pix_cnt", bus.pix_cnt, m_cnt);
      end
      if (k == len) bus.pre_vs = 1'b0;
    end
    chk("box_valid", bus.box_valid, m_valid);
  endtask
  initial begin
    int d, dens;
    bus.pre_vs = 0; bus.pre_hs = 0; bus.pre_clken = 0; bus.pre_imgbit = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    m_clear();
    frame(0, H, W, 100); vsync(0, 0);
    frame(1, H, W, 0); vsync(1, 0);
    frame(2, 4, W, 0); vsync(1, 0);
    frame(1, H, W, 0); vsync(1, 0);
    repeat (5) begin frame(4, 3, W, 0); vsync(1, 0); end
    frame(3, H + 3, W + 6, 0); vsync(1, 0);
    repeat (25) begin
      d = $urandom_range(4);
      dens = d == 0 ? 0 : d == 1 ? 3 : d == 2 ? 15 : d == 3 ? 50 : 100;
      frame(0, $urandom_range(1, H + 3), $urandom_range(1, W + 6), dens);
      vsync(1, 1'($urandom_range(1)));
    end
    frame(1, H, W, 0); vsync(1, 0);
    frame(0, 3, W, 50);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 0;
    m_clear();
    frame(0, H, W, 50); vsync(0, 0);
    frame(1, H, W, 0); vsync(1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
